// File: rtl/debug_pkg.sv
// Shared constants for the debug display scanner: blank patterns, the hex
// segment table and the button debounce state encodings.
package debug_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [3:0] AN_OFF    = 4'b1111;

    // Active-low {g,f,e,d,c,b,a}; entry 15 (F) is the leftmost element.
    localparam logic [15:0][6:0] HEX_SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    typedef enum logic [2:0] {
        DB_IDLE    = 3'd0,
        DB_ARMING  = 3'd1,
        DB_PRESSED = 3'd2,
        DB_HELD    = 3'd3,
        DB_RELEASE = 3'd4
    } db_state_t;

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational nibble to active-low seven-segment decoder.
module hex_to_seg7
    import debug_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    assign o_seg = HEX_SEG_TABLE[i_nibble];

endmodule

// File: rtl/debug_display_scan_ctrl.sv
// Multiplexes one of four 16-bit debug words onto a 4-digit 7-segment display,
// with page selection by debounced pushbutton or automatic rotation.
module debug_display_scan_ctrl
    import debug_pkg::*;
#(
    parameter int SCAN_DIV     = 100000,
    parameter int DEBOUNCE_CYC = 500000,
    parameter int AUTO_FRAMES  = 256
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [15:0] dbg_word0,
    input  logic [15:0] dbg_word1,
    input  logic [15:0] dbg_word2,
    input  logic [15:0] dbg_word3,
    input  logic        btn_next,
    input  logic        auto_en,
    output logic [3:0]  AN,
    output logic [7:0]  SEG,
    output logic [1:0]  page
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DW = $clog2(DEBOUNCE_CYC + 1);
    localparam int AW = $clog2(AUTO_FRAMES + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYC - 1);
    localparam logic [AW-1:0] AUTO_LAST  = AW'(AUTO_FRAMES - 1);

    logic [PW-1:0] r_presc;
    logic [1:0]    r_digit;
    logic [1:0]    r_page;
    logic [1:0]    r_pending;
    logic [15:0]   r_snapshot;
    logic [AW-1:0] r_auto_cnt;
    logic [3:0]    r_an;
    logic [7:0]    r_seg;
    logic          r_sync1;
    logic          r_sync2;
    db_state_t     r_db_state;
    logic [DW-1:0] r_db_cnt;

    db_state_t     w_db_state_next;
    logic [DW-1:0] w_db_cnt_next;
    logic          w_btn_pulse;
    logic          w_slot_tick;
    logic          w_frame_tick;
    logic          w_auto_pulse;
    logic [6:0]    w_seg7;
    logic [15:0]   w_words [4];

    assign w_words[0] = dbg_word0;
    assign w_words[1] = dbg_word1;
    assign w_words[2] = dbg_word2;
    assign w_words[3] = dbg_word3;

    assign w_slot_tick  = (r_presc == PRESC_LAST);
    assign w_frame_tick = w_slot_tick && (r_digit == 2'd3);
    assign w_auto_pulse = auto_en && w_frame_tick && (r_auto_cnt == AUTO_LAST);

    // The digit being lit this slot reads the snapshot before any frame update,
    // so digit 3 still shows the old word while the new one is latched.
    hex_to_seg7 u_hex (
        .i_nibble (r_snapshot[{r_digit, 2'b00} +: 4]),
        .o_seg    (w_seg7)
    );

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_presc    <= '0;
            r_digit    <= 2'd0;
            r_page     <= 2'd0;
            r_pending  <= 2'd0;
            r_snapshot <= 16'h0000;
            r_auto_cnt <= '0;
            r_an       <= AN_OFF;
            r_seg      <= SEG_BLANK;
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_db_state <= DB_IDLE;
            r_db_cnt   <= '0;
        end else begin
            r_presc    <= w_slot_tick ? '0 : r_presc + PW'(1);
            r_sync1    <= btn_next;
            r_sync2    <= r_sync1;
            r_db_state <= w_db_state_next;
            r_db_cnt   <= w_db_cnt_next;
            if (w_slot_tick) begin
                r_digit <= r_digit + 2'd1;
                r_an    <= ~(4'b0001 << r_digit);
                r_seg   <= {(r_digit != r_page), w_seg7};
            end
            if (w_frame_tick) begin
                r_page     <= r_pending;
                r_snapshot <= w_words[r_pending];
            end
            // Button and auto requests in the same cycle merge into one step.
            if (w_btn_pulse || w_auto_pulse) begin
                r_pending <= r_pending + 2'd1;
            end
            if (!auto_en || w_btn_pulse) begin
                r_auto_cnt <= '0;
            end else if (w_frame_tick) begin
                r_auto_cnt <= (r_auto_cnt == AUTO_LAST) ? '0 : r_auto_cnt + AW'(1);
            end
        end
    end

    always_comb begin
        w_db_state_next = r_db_state;
        w_db_cnt_next   = r_db_cnt;
        w_btn_pulse     = 1'b0;
        case (r_db_state)
            DB_IDLE: begin
                if (r_sync2) begin
                    w_db_state_next = DB_ARMING;
                    w_db_cnt_next   = '0;
                end
            end
            DB_ARMING: begin
                if (!r_sync2) begin
                    w_db_state_next = DB_IDLE;
                end else if (r_db_cnt == DB_LAST) begin
                    w_db_state_next = DB_PRESSED;
                end else begin
                    w_db_cnt_next = r_db_cnt + DW'(1);
                end
            end
            DB_PRESSED: begin
                w_btn_pulse     = 1'b1;
                w_db_state_next = DB_HELD;
            end
            DB_HELD: begin
                if (!r_sync2) begin
                    w_db_state_next = DB_RELEASE;
                    w_db_cnt_next   = '0;
                end
            end
            DB_RELEASE: begin
                if (r_sync2) begin
                    w_db_state_next = DB_HELD;
                end else if (r_db_cnt == DB_LAST) begin
                    w_db_state_next = DB_IDLE;
                end else begin
                    w_db_cnt_next = r_db_cnt + DW'(1);
                end
            end
            default: begin
                w_db_state_next = DB_IDLE;
            end
        endcase
    end

    assign AN   = r_an;
    assign SEG  = r_seg;
    assign page = r_page;

endmodule
